// File: rtl/dtfm_transmitter.sv
// Serial source for the dCLK/dFM/dDAT telemetry link: parallel words in over
// valid/ready, MSB-first bit stream out with a word-0 frame-sync marker.
module dtfm_transmitter #(
  parameter  int WORD_W      = 12,
  parameter  int FRAME_WORDS = 1024,
  parameter  int HALF_DIV    = 3,
  localparam int IDX_W       = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1,
  localparam int DIV_W       = $clog2(2 * HALF_DIV),
  localparam int BIT_W       = (WORD_W > 1) ? $clog2(WORD_W) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [WORD_W-1:0] iWord,
  input  logic              iValid,
  output logic              oReady,
  output logic              dCLK,
  output logic              dFM,
  output logic              dDAT,
  output logic              oBusy,
  output logic [IDX_W-1:0]  oWordIdx,
  output logic              oUnderrun,
  output logic              oFrameDone
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(2 * HALF_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(HALF_DIV);
  localparam logic [BIT_W-1:0] BIT_MAX  = BIT_W'(WORD_W - 1);
  localparam logic [IDX_W-1:0] WORD_MAX = IDX_W'(FRAME_WORDS - 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [DIV_W-1:0]    r_div;
  logic [BIT_W-1:0]    r_bit;
  logic [IDX_W-1:0]    r_word;
  logic [WORD_W-1:0]   r_shift;
  logic                r_dclk;
  logic                r_dfm;
  logic                r_ddat;

  logic                w_run;
  logic                w_div_wrap;
  logic                w_bit_wrap;
  logic                w_frame_end;
  logic                w_slot;

  assign w_run       = (r_state == S_RUN);
  assign w_div_wrap  = (r_div == DIV_MAX);
  assign w_bit_wrap  = w_div_wrap && (r_bit == BIT_MAX);
  assign w_frame_end = w_bit_wrap && (r_word == WORD_MAX);
  assign w_slot      = w_run && (r_div == '0) && (r_bit == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // en is only looked at in IDLE and at the final cycle of a frame, so a
  // frame in progress always runs to completion.
  always_comb begin
    w_state_nxt = r_state;
    oReady      = 1'b0;
    oUnderrun   = 1'b0;
    oFrameDone  = 1'b0;
    oBusy       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (en) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        oBusy      = 1'b1;
        oReady     = w_slot;
        oUnderrun  = w_slot && !iValid;
        oFrameDone = w_frame_end;
        if (w_frame_end && !en) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: the shift register is an ordinary flop vector, so it is reset with
  // everything else; an underrun loads zeros rather than stretching the frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div   <= '0;
      r_bit   <= '0;
      r_word  <= '0;
      r_shift <= '0;
      r_dclk  <= 1'b0;
      r_dfm   <= 1'b0;
      r_ddat  <= 1'b0;
    end else if (w_run) begin
      r_div <= w_div_wrap ? '0 : r_div + 1'b1;
      if (w_div_wrap) begin
        r_bit <= w_bit_wrap ? '0 : r_bit + 1'b1;
        if (w_bit_wrap) r_word <= w_frame_end ? '0 : r_word + 1'b1;
      end

      if (r_div == '0) begin
        r_dclk <= 1'b1;
        r_dfm  <= (r_word == '0);
        if (r_bit == '0) begin
          r_ddat  <= iValid & iWord[WORD_W-1];
          r_shift <= iValid ? (iWord << 1) : '0;
        end else begin
          r_ddat  <= r_shift[WORD_W-1];
          r_shift <= r_shift << 1;
        end
      end else if (r_div == DIV_HALF) begin
        r_dclk <= 1'b0;
      end

      // Leaving RUN: the line drops to all-zero at the frame-end edge.
      if (w_frame_end && !en) begin
        r_dclk  <= 1'b0;
        r_dfm   <= 1'b0;
        r_ddat  <= 1'b0;
        r_shift <= '0;
      end
    end
  end

  assign dCLK     = r_dclk;
  assign dFM      = r_dfm;
  assign dDAT     = r_ddat;
  assign oWordIdx = r_word;

endmodule

// File: tb/tb_dtfm_transmitter.sv
// Self-checking bench for dtfm_transmitter: table-driven word stream, a
// scoreboard fed at each word slot, and a line receiver model sampling dDAT on dCLK falls.
module tb_dtfm_transmitter;

  localparam int WW = 12;
  localparam int FW = 4;
  localparam int HD = 2;
  localparam int BIT_P   = 2 * HD;
  localparam int WORD_P  = WW * BIT_P;
  localparam int FRAME_P = FW * WORD_P;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [WW-1:0] iWord;
  logic          iValid;
  logic          oReady, dCLK, dFM, dDAT, oBusy, oUnderrun, oFrameDone;
  logic [1:0]    oWordIdx;

  dtfm_transmitter #(.WORD_W(WW), .FRAME_WORDS(FW), .HALF_DIV(HD)) dut (
    .clk(clk), .rst(rst), .en(en), .iWord(iWord), .iValid(iValid),
    .oReady(oReady), .dCLK(dCLK), .dFM(dFM), .dDAT(dDAT), .oBusy(oBusy),
    .oWordIdx(oWordIdx), .oUnderrun(oUnderrun), .oFrameDone(oFrameDone)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WW-1:0] word;
    logic          valid;
    logic [WW-1:0] exp_word;
    logic          exp_ur;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  logic [WW-1:0] sb_q[$];

  // receiver / monitor state
  logic          p_dclk = 1'b0, p_dfm = 1'b0, p_ddat = 1'b0;
  logic          rise_c, fall_c;
  logic          rx_synced = 1'b0;
  int            rx_cnt = 0;
  logic [WW-1:0] rx_sh = '0;
  logic [WW-1:0] rx_exp;
  int n_rx = 0, n_ready = 0, n_ur = 0, n_fd = 0, n_fm_rise = 0;
  int t_rdy = 0, t_fm = 0, t_clk = 0, t_w0 = 0;
  bit t_rdy_ok = 0, t_fm_ok = 0, t_clk_ok = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Present one word until the DUT takes it at a slot; push the expected line word.
  task automatic send(input logic [WW-1:0] w, input logic v, input logic [WW-1:0] ew,
                      input logic eu, input int idx);
    bit got = 0;
    iWord  = w;
    iValid = v;
    for (int t = 0; t < 200 && !got; t++) begin
      #1;
      if (oReady) begin
        got = 1;
        sb_q.push_back(ew);
        check("underrun_flag", oUnderrun, eu);
        check("word_idx", oWordIdx, idx);
      end
      @(posedge clk);
      #1;
    end
    check("ready_seen", got, 1);
  endtask

  task automatic wait_idle(input string name);
    bit got = 0;
    for (int t = 0; t < 400 && !got; t++) begin
      @(posedge clk);
      #2;
      if (!oBusy) got = 1;
    end
    check(name, got, 1);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      sb_q.delete();
      rx_synced = 1'b0;
      rx_cnt    = 0;
      rx_sh     = '0;
      t_rdy_ok  = 0;
      t_fm_ok   = 0;
      t_clk_ok  = 0;
    end else begin
      rise_c = dCLK & ~p_dclk;
      fall_c = ~dCLK & p_dclk;
      if (oReady) begin
        n_ready++;
        if (t_rdy_ok) check("ready_spacing", cyc - t_rdy, WORD_P);
        t_rdy    = cyc;
        t_rdy_ok = 1;
        if (oWordIdx == 2'd0) t_w0 = cyc;
      end
      if (oUnderrun) n_ur++;
      if (oFrameDone) begin
        n_fd++;
        check("frame_done_pos", cyc - t_w0, FRAME_P - 1);
      end
      if (oBusy && (dDAT != p_ddat || dFM != p_dfm)) check("line_change_on_rise", rise_c, 1);
      if (rise_c) begin
        if (t_clk_ok) check("dclk_period", cyc - t_clk, BIT_P);
        t_clk    = cyc;
        t_clk_ok = 1;
      end
      if (dFM && !p_dfm) begin
        n_fm_rise++;
        check("fm_with_clk_rise", rise_c, 1);
        if (t_fm_ok) check("fm_spacing", cyc - t_fm, FRAME_P);
        t_fm      = cyc;
        t_fm_ok   = 1;
        rx_synced = 1'b1;
        rx_cnt    = 0;
      end
      if (!dFM && p_dfm && oBusy) check("fm_high_len", cyc - t_fm, WORD_P);
      if (fall_c && rx_synced) begin
        rx_sh = {rx_sh[WW-2:0], dDAT};
        rx_cnt++;
        if (rx_cnt == WW) begin
          rx_cnt = 0;
          n_rx++;
          if (sb_q.size() == 0) begin
            check("rx_word_expected", sb_q.size(), 1);
          end else begin
            rx_exp = sb_q.pop_front();
            check("rx_word", rx_sh, rx_exp);
          end
        end
      end
      if (!oBusy) begin
        t_rdy_ok = 0;
        t_fm_ok  = 0;
        t_clk_ok = 0;
      end
    end
    p_dclk = dCLK;
    p_dfm  = dFM;
    p_ddat = dDAT;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
    $fatal(1);
  end

  initial begin
    vec_t vecs[12];
    int   s_ready, s_rx, s_fm, s_fd;

    vecs[0]  = '{12'hA5C, 1'b1, 12'hA5C, 1'b0};
    vecs[1]  = '{12'h123, 1'b1, 12'h123, 1'b0};
    vecs[2]  = '{12'hFFF, 1'b1, 12'hFFF, 1'b0};
    vecs[3]  = '{12'h001, 1'b1, 12'h001, 1'b0};
    vecs[4]  = '{12'h5A3, 1'b1, 12'h5A3, 1'b0};
    vecs[5]  = '{12'h0F0, 1'b1, 12'h0F0, 1'b0};
    vecs[6]  = '{12'hBAD, 1'b0, 12'h000, 1'b1};
    vecs[7]  = '{12'h800, 1'b1, 12'h800, 1'b0};
    vecs[8]  = '{12'h7FF, 1'b1, 12'h7FF, 1'b0};
    vecs[9]  = '{12'h000, 1'b1, 12'h000, 1'b0};
    vecs[10] = '{12'h555, 1'b1, 12'h555, 1'b0};
    vecs[11] = '{12'hAAA, 1'b1, 12'hAAA, 1'b0};

    rst = 1'b1; en = 1'b0; iWord = '0; iValid = 1'b0;
    #12;
    check("rst_dclk", dCLK, 0);
    check("rst_dfm", dFM, 0);
    check("rst_ddat", dDAT, 0);
    check("rst_busy", oBusy, 0);
    check("rst_ready", oReady, 0);
    check("rst_idx", oWordIdx, 0);
    check("rst_framedone", oFrameDone, 0);

    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1; en = 1'b1;

    // Three back-to-back frames; underrun at frame 2 word 2; en drops in frame 3 word 1.
    for (int i = 0; i < 12; i++) begin
      send(vecs[i].word, vecs[i].valid, vecs[i].exp_word, vecs[i].exp_ur, i % FW);
      if (i == 9) en = 1'b0;
    end
    wait_idle("stop_reaches_idle");
    check("stop_dclk", dCLK, 0);
    check("stop_dfm", dFM, 0);
    check("stop_ddat", dDAT, 0);
    check("stop_busy", oBusy, 0);
    s_ready = n_ready;
    repeat (60) @(posedge clk);
    #1;
    check("no_ready_after_stop", n_ready - s_ready, 0);
    check("run1_fm_rises", n_fm_rise, 3);
    check("run1_frame_done", n_fd, 3);
    check("run1_underruns", n_ur, 1);
    check("run1_rx_words", n_rx, 12);
    check("run1_sb_empty", sb_q.size(), 0);

    // Reset in word 2, bit 5 of a fresh frame.
    en = 1'b1;
    send(12'h321, 1'b1, 12'h321, 1'b0, 0);
    send(12'h654, 1'b1, 12'h654, 1'b0, 1);
    send(12'h987, 1'b1, 12'h987, 1'b0, 2);
    repeat (20) @(posedge clk);
    #1;
    check("pre_rst_dclk_high", dCLK, 1);
    check("pre_rst_idx", oWordIdx, 2);
    rst = 1'b1;
    #1;
    check("async_rst_dclk", dCLK, 0);
    check("async_rst_dfm", dFM, 0);
    check("async_rst_ddat", dDAT, 0);
    check("async_rst_busy", oBusy, 0);
    check("async_rst_ready", oReady, 0);
    check("async_rst_idx", oWordIdx, 0);
    repeat (2) @(posedge clk);
    #1;
    s_rx = n_rx; s_fm = n_fm_rise; s_fd = n_fd;
    rst = 1'b0;

    send(12'hC3A, 1'b1, 12'hC3A, 1'b0, 0);
    en = 1'b0;
    check("restart_fm_high", dFM, 1);
    send(12'h5F0, 1'b1, 12'h5F0, 1'b0, 1);
    send(12'h0E1, 1'b1, 12'h0E1, 1'b0, 2);
    send(12'hB7D, 1'b1, 12'hB7D, 1'b0, 3);
    wait_idle("restart_reaches_idle");
    check("restart_rx_words", n_rx - s_rx, 4);
    check("restart_fm_rises", n_fm_rise - s_fm, 1);
    check("restart_frame_done", n_fd - s_fd, 1);
    check("restart_sb_empty", sb_q.size(), 0);
    check("restart_idle_dclk", dCLK, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
